// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the Mini-TPU operand-memory feed controller.
package tpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DIM        = 4;
    localparam int SKEW_LEN   = 2 * DIM - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        FEED  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/skew_gen.sv
// Wavefront decoder: column c reads element (t-c) while 0 <= t-c <= 3, so each
// column lags its left neighbour by one cycle.
module skew_gen #(
    parameter int DIM = tpu_pkg::DIM
) (
    input  logic [2:0]       t,
    input  logic             en,
    output logic [DIM-1:0]   read_enable,
    output logic [2*DIM-1:0] read_elem
);

    for (genvar c = 0; c < DIM; c++) begin : g_col
        localparam logic [2:0] COL = 3'(c);
        logic [2:0] diff_s;

        assign diff_s                 = t - COL;
        assign read_enable[c]         = en && (t >= COL) && (diff_s <= 3'd3);
        assign read_elem[2*c+1 -: 2]  = read_enable[c] ? diff_s[1:0] : 2'd0;
    end

endmodule

// File: rtl/mem_feed_ctrl.sv
// Loads a 4x4 operand matrix from a valid/ready stream and feeds it out as a skewed wavefront.
// Optional build macro FEED_CNT_EN adds a 16-bit count of completed feed passes.
module mem_feed_ctrl #(
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int DIM        = tpu_pkg::DIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  clear,
    input  logic                  start,
    output logic                  mem_write_enable,
    output logic [1:0]            mem_write_line,
    output logic [1:0]            mem_write_elem,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DIM-1:0]        mem_read_enable,
    output logic [2*DIM-1:0]      mem_read_elem,
    output logic                  loaded,
    output logic                  busy,
    output logic                  done
`ifdef FEED_CNT_EN
    ,
    output logic [15:0]           feed_count
`endif
);
    import tpu_pkg::*;

    localparam logic [2:0] T_LAST = 3'(SKEW_LEN - 1);

    feed_state_t state_r;
    feed_state_t state_nxt_s;
    logic [2:0]  t_r;
    logic [2:0]  t_nxt_s;
    logic [3:0]  wr_cnt_r;
    logic [3:0]  wr_cnt_nxt_s;
    logic        accept_s;

    // in_ready is itself a register that is only high in EMPTY/LOAD.
    assign accept_s = in_valid & in_ready;
    assign loaded   = (state_r == FULL) || (state_r == FEED);
    assign busy     = (state_r == FEED);

    skew_gen #(.DIM(DIM)) u_skew_gen (
        .t           (t_r),
        .en          (busy),
        .read_enable (mem_read_enable),
        .read_elem   (mem_read_elem)
    );

    // State, feed step and write counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= EMPTY;
            t_r      <= 3'd0;
            wr_cnt_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            t_r      <= t_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
        end
    end

    // Next-state logic; clear outranks both a load completion and a start request.
    always_comb begin
        state_nxt_s  = state_r;
        t_nxt_s      = t_r;
        wr_cnt_nxt_s = wr_cnt_r;
        case (state_r)
            EMPTY, LOAD: begin
                if (clear) begin
                    state_nxt_s  = EMPTY;
                    wr_cnt_nxt_s = 4'd0;
                end else if (accept_s) begin
                    if (wr_cnt_r == 4'd15) begin
                        state_nxt_s  = FULL;
                        wr_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s  = LOAD;
                        wr_cnt_nxt_s = wr_cnt_r + 4'd1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FULL: begin
                if (clear) begin
                    state_nxt_s = EMPTY;
                end else if (start) begin
                    state_nxt_s = FEED;
                    t_nxt_s     = 3'd0;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            FEED: begin
                if (t_r == T_LAST) begin
                    state_nxt_s = FULL;
                    t_nxt_s     = 3'd0;
                end else begin
                    t_nxt_s     = t_r + 3'd1;
                end
            end
            default: begin
                state_nxt_s  = EMPTY;
                t_nxt_s      = 3'd0;
                wr_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Registered stream handshake, memory write port and pass-complete strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready         <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_write_line   <= 2'd0;
            mem_write_elem   <= 2'd0;
            mem_data_in      <= {DATA_WIDTH{1'b0}};
            done             <= 1'b0;
        end else begin
            in_ready         <= (state_nxt_s == EMPTY) || (state_nxt_s == LOAD);
            mem_write_enable <= accept_s;
            if (accept_s) begin
                mem_write_line <= wr_cnt_r[3:2];
                mem_write_elem <= wr_cnt_r[1:0];
                mem_data_in    <= in_data;
            end
            done <= busy && (t_r == T_LAST);
        end
    end

`ifdef FEED_CNT_EN
    // Completed-pass counter, advanced together with the done strobe; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feed_count <= 16'd0;
        end else if (busy && (t_r == T_LAST)) begin
            feed_count <= feed_count + 16'd1;
        end
    end
`else
    // Without the counter, pass completion is visible only through done.
`endif

endmodule

// File: doc/mem_feed_ctrl.md
Name: mem_feed_ctrl

Overview:
Controller for the 4x4 operand memory of the Mini-TPU. It sequences the memory's write port to load a full matrix from a valid/ready stream. It then drives the four per-column read ports in a skewed wavefront, where column c lags column c-1 by one cycle, to feed the systolic array edge. It tracks empty/loading/loaded state and reports completion of each feed pass.

Parameters:
DATA_WIDTH, 8, operand width; matches the memory cell width.
DIM, 4, array dimension; only 4 is supported, because memory addressing is 2-bit.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  load stream word valid
in_ready  output  1  load stream ready
in_data  input  DATA_WIDTH  load stream word
clear  input  1  discard the loaded matrix
start  input  1  request one feed pass
mem_write_enable  output  1  to memory write_enable
mem_write_line  output  2  to memory write_line
mem_write_elem  output  2  to memory write_elem
mem_data_in  output  DATA_WIDTH  to memory data_in
mem_read_enable  output  4  to memory read_enable; bit c = column c
mem_read_elem  output  8  to memory read_elem; column c occupies bits [2c+1:2c]
loaded  output  1  full matrix resident
busy  output  1  feed pass in progress
done  output  1  one-cycle pulse at end of a feed pass

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- On reset: state=EMPTY, wr_cnt=0, t=0, all outputs 0. in_ready is 1 from the first cycle after rst deasserts. Memory contents are not touched.
- States: EMPTY, LOAD, FULL, FEED.
- No combinational path from any input to any output. All outputs are decoded from registers.
- EMPTY/LOAD:
  - in_ready=1.
  - Accept = in_valid & in_ready at a posedge.
  - An accept registers mem_write_enable=1, mem_write_line=wr_cnt[3:2], mem_write_elem=wr_cnt[1:0], mem_data_in=in_data. These are held one cycle, so the memory writes at the next posedge (write latency 1).
  - A non-accept cycle registers mem_write_enable=0.
  - wr_cnt increments per accept.
  - First accept: EMPTY->LOAD. The 16th accept (wr_cnt=15) moves to FULL and resets wr_cnt to 0.
- FULL:
  - loaded=1, in_ready=0.
  - clear -> EMPTY.
  - Otherwise start -> FEED with t=0.
  - clear and start in the same cycle: clear wins, no feed.
- FEED:
  - busy=1, loaded=1. t counts 0..6 (2*DIM-1 cycles).
  - mem_read_enable[c] = (t>=c) && (t-c<=3). mem_read_elem column c = (t-c)[1:0] when enabled, else 0.
  - At t=6 -> FULL, and done=1 in the first FULL cycle.
  - start and clear are ignored during FEED and must be presented again in FULL.
  - The matrix is retained, so repeated start is allowed without a reload.
- clear in LOAD -> EMPTY with wr_cnt=0. A write registered in the same cycle still completes. The partial data is left stale in memory.
- start in EMPTY/LOAD is ignored and not latched.
- rst mid-operation: immediate return to EMPTY and all-zero outputs. An in-flight write is dropped.

Optional Feature:
FEED_CNT_EN:
- Defined: adds output feed_count (16 bits). It increments on each done pulse, wraps 0xFFFF->0x0000, and is cleared only by rst.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package tpu_pkg holds:
  - DATA_WIDTH and DIM constants.
  - SKEW_LEN = 2*DIM-1.
  - typedef feed_state_t {EMPTY, LOAD, FULL, FEED}.
- One sub-module: skew_gen, combinational, mapping t to mem_read_enable/mem_read_elem. It is instantiated once.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously. After release: in_ready=1, loaded=0, busy=0.
- Load of 0x01..0x10 back-to-back:
  - Writes appear one cycle after each accept at (line,elem) = (0,0),(0,1)..(3,3) with data 0x01..0x10.
  - in_ready=0 and loaded=1 after the 16th accept.
- Gapped load, in_valid every other cycle -> exactly 16 writes, no duplicate addresses, FULL after the 16th accept.
- start in FULL -> busy for 7 cycles:
  - t=0: enable=0001, col0 elem=0.
  - t=3: enable=1111, elems col0..3 = 3,2,1,0.
  - t=6: enable=1000, col3 elem=3.
  - done one cycle later. A second start re-runs the pass without a reload.
- start+clear together in FULL -> EMPTY, no read enables, loaded=0. Separately, clear after 5 accepts in LOAD -> the next accepted word is written to (0,0).
- rst asserted at t=3 of a feed -> mem_read_enable=0000 immediately, EMPTY, no done. With FEED_CNT_EN, feed_count=0.
